// File: rtl/xnor_frame_parity.sv
// Frame-level XOR/XNOR reduction over up to FRAME_LEN words.
// Every output is registered, and the result is held until it is consumed.
module xnor_frame_parity #(
    parameter int  WIDTH     = 8,
    parameter int  FRAME_LEN = 4,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode_xnor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_short
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state;
    logic            acc;
    logic            mode_r;
    logic [CW-1:0]   cnt;

    logic            take;
    logic            nacc;
    logic            nmode;
    logic            close;
    logic [CW-1:0]   ncnt;

    // IDLE and ACCUM share one update path: IDLE seeds the frame and ACCUM folds into it.
    always_comb begin
        take  = in_valid && in_ready;
        nacc  = (state == ACCUM) ? (acc ^ (^in_data)) : (^in_data);
        ncnt  = (state == ACCUM) ? (cnt + CW'(1)) : CW'(1);
        nmode = (state == ACCUM) ? mode_r : mode_xnor;
        close = in_last || (ncnt == CW'(FRAME_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            mode_r     <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_count  <= '0;
            out_short  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (take) begin
                        acc    <= nacc;
                        cnt    <= ncnt;
                        mode_r <= nmode;
                        if (close) begin
                            state      <= DONE;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            out_parity <= nmode ? ~nacc : nacc;
                            out_count  <= ncnt;
                            out_short  <= (ncnt < CW'(FRAME_LEN));
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        out_valid  <= 1'b0;
                        out_parity <= 1'b0;
                        out_count  <= '0;
                        out_short  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xnor_frame_parity.sv
// Self-checking bench: table-driven frames scored through a queue, plus hand-written
// sequences for back-pressure, mid-frame reset and a FRAME_LEN=1 sweep.
module tb_xnor_frame_parity;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_last, mode_xnor;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_parity, out_short;
    logic [2:0] out_count;

    logic       in1_valid, in1_ready, out1_valid, out1_parity, out1_short;
    logic [2:0] in1_data;
    logic [0:0] out1_count;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0][7:0] w;
        int              n;
        logic            mode;
        logic            tog;
        logic            lst;
        logic            gap;
        logic            ep;
        int              ec;
        logic            es;
    } vec_t;

    typedef struct {
        logic p;
        int   c;
        logic s;
    } exp_t;

    exp_t sb[$];

    xnor_frame_parity #(.WIDTH(8), .FRAME_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .mode_xnor(mode_xnor),
        .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
        .out_count(out_count), .out_short(out_short)
    );

    xnor_frame_parity #(.WIDTH(3), .FRAME_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
        .in_last(1'b0), .mode_xnor(1'b1),
        .out_valid(out1_valid), .out_ready(1'b1), .out_parity(out1_parity),
        .out_count(out1_count), .out_short(out1_short)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    // Scoreboard side: pop on each consumed result, and insist on zeros while idle.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_parity", int'(out_parity), int'(e.p));
                check("sb_count", int'(out_count), e.c);
                check("sb_short", int'(out_short), int'(e.s));
            end
        end
        if (!out_valid)
            check("idle_zero", int'({out_parity, out_count, out_short}), 0);
    end

    task automatic send_word(input logic [7:0] d, input logic l, input logic m);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_last = l; mode_xnor = m;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            send_word(v.w[i], v.lst && (i == v.n - 1), v.mode ^ (v.tog && (i % 2 == 1)));
            if (v.gap && i < v.n - 1) begin
                // Garbage presented with in_valid low must be ignored.
                in_data = 8'hFF; in_last = 1'b1; mode_xnor = ~v.mode;
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("latency_out_valid", int'(out_valid), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    vec_t       vt[7];
    exp_t       e;
    logic [7:0] sweep_exp;

    initial begin
        in_valid = 0; in_data = 0; in_last = 0; mode_xnor = 0; out_ready = 1;
        in1_valid = 0; in1_data = 0;
        rst_n = 0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_outputs", int'({out_parity, out_count, out_short}), 0);
        #10 rst_n = 1;
        @(negedge clk);
        check("in_ready_after_rst", int'(in_ready), 1);

        //           words (w[3]..w[0])          n  mode tog lst gap ep ec es
        vt[0] = '{32'h00_00_03_01,            4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
        vt[1] = '{32'h00_00_03_01,            4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0};
        vt[2] = '{32'h00_00_80_FF,            2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1};
        vt[3] = '{32'h00_00_00_07,            1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1};
        vt[4] = '{32'h01_0F_55_AA,            4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0};
        vt[5] = '{32'h00_80_22_11,            3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1};
        vt[6] = '{32'h00_00_00_00,            4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0};

        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            e = '{vt[i].ep, vt[i].ec, vt[i].es};
            sb.push_back(e);
            send_frame(vt[i]);
            drain();
        end

        // Back-pressure: result must hold for three stalled cycles.
        out_ready = 0;
        e = '{1'b0, 4, 1'b0};
        sb.push_back(e);
        send_frame(vt[0]);
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_parity", int'(out_parity), 0);
            check("hold_count", int'(out_count), 4);
            check("hold_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1;
        drain();
        @(negedge clk);
        check("post_hold_valid", int'(out_valid), 0);
        check("post_hold_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Mid-frame reset discards the partial frame.
        send_word(8'h01, 1'b0, 1'b1);
        send_word(8'h03, 1'b0, 1'b1);
        rst_n = 0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_outputs", int'({out_parity, out_count, out_short}), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("midrst_in_ready_back", int'(in_ready), 1);
        @(posedge clk); #1;
        vt[0] = '{32'h00_00_00_01, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0};
        e = '{1'b1, 4, 1'b0};
        sb.push_back(e);
        send_frame(vt[0]);
        drain();

        // FRAME_LEN=1, 3-bit XNOR sweep.
        sweep_exp = 8'b0110_1001;
        for (int v = 0; v < 8; v++) begin
            bit ok = 0;
            in1_valid = 1'b1; in1_data = 3'(v);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (in1_ready) begin
                    @(posedge clk); #1;
                    ok = 1;
                    break;
                end
            end
            if (!ok) check("sweep_ready_timeout", 0, 1);
            in1_valid = 1'b0;
            @(negedge clk);
            check("sweep_valid", int'(out1_valid), 1);
            check("sweep_parity", int'(out1_parity), int'(sweep_exp[v]));
            check("sweep_count_short", int'({out1_count, out1_short}), 2);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
